// File: rtl/lectura_rtc.sv
// ============================================================================
//  Module   : lectura_rtc
//  Brief    : RTC multiplexed-bus read sequencer; sweeps eleven registers and
//             commits them atomically to the datos* outputs.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module lectura_rtc #(
    parameter int TPULSE = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [7:0] AD_in,
    output logic [7:0] AD_out,
    output logic       ad_oe,
    output logic       ad_sel,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       ocupado,
    output logic       listo,
    output logic [7:0] datos0,
    output logic [7:0] datos1,
    output logic [7:0] datos2,
    output logic [7:0] datos3,
    output logic [7:0] datos4,
    output logic [7:0] datos5,
    output logic [7:0] datos6,
    output logic [7:0] datos7,
    output logic [7:0] datos8,
    output logic [7:0] datos9,
    output logic [7:0] datos10
);

    localparam int              c_CW   = (TPULSE > 1) ? $clog2(TPULSE) : 1;
    localparam logic [c_CW-1:0] c_TC   = c_CW'(TPULSE - 1);
    localparam logic [3:0]      c_LAST = 4'd10;

    typedef enum logic [2:0] {
        ST_IDLE, ST_A_SET, ST_A_WR, ST_A_HLD, ST_D_SET, ST_D_RD, ST_D_HLD, ST_COMMIT
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [3:0]      r_idx, w_idx_nxt;
    logic [c_CW-1:0] r_cnt;
    logic            w_tc;
    logic [7:0]      r_shadow [0:10];
    logic [7:0]      r_datos  [0:10];

    logic [7:0] r_ad_out, w_ad_out;
    logic       r_ad_oe, r_ad_sel, r_cs_n, r_rd_n, r_wr_n, r_ocupado, r_listo;
    logic       w_ad_oe, w_ad_sel, w_cs_n, w_rd_n, w_wr_n;

    function automatic logic [7:0] addr_of(input logic [3:0] i);
        case (i)
            4'd0:    addr_of = 8'h21;
            4'd1:    addr_of = 8'h22;
            4'd2:    addr_of = 8'h23;
            4'd3:    addr_of = 8'h24;
            4'd4:    addr_of = 8'h25;
            4'd5:    addr_of = 8'h26;
            4'd6:    addr_of = 8'h27;
            4'd7:    addr_of = 8'h28;
            4'd8:    addr_of = 8'h41;
            4'd9:    addr_of = 8'h42;
            4'd10:   addr_of = 8'h43;
            default: addr_of = 8'h00;
        endcase
    endfunction

    assign w_tc = (r_cnt == c_TC);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            if (w_state_nxt != r_state) begin
                r_cnt <= '0;
            end else if (!w_tc) begin
                r_cnt <= r_cnt + c_CW'(1);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            ST_IDLE: begin
                if (iniciar) begin
                    w_state_nxt = ST_A_SET;
                    w_idx_nxt   = '0;
                end
            end
            ST_A_SET: if (w_tc) w_state_nxt = ST_A_WR;
            ST_A_WR:  if (w_tc) w_state_nxt = ST_A_HLD;
            ST_A_HLD: if (w_tc) w_state_nxt = ST_D_SET;
            ST_D_SET: if (w_tc) w_state_nxt = ST_D_RD;
            ST_D_RD:  if (w_tc) w_state_nxt = ST_D_HLD;
            ST_D_HLD: begin
                if (w_tc) begin
                    if (r_idx == c_LAST) begin
                        w_state_nxt = ST_COMMIT;
                    end else begin
                        w_state_nxt = ST_A_SET;
                        w_idx_nxt   = r_idx + 4'd1;
                    end
                end
            end
            ST_COMMIT: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Bus pins are decoded from the next state so the registered copies line up with the state.
    always_comb begin
        w_cs_n   = 1'b1;
        w_rd_n   = 1'b1;
        w_wr_n   = 1'b1;
        w_ad_oe  = 1'b0;
        w_ad_sel = 1'b1;
        w_ad_out = 8'h00;
        case (w_state_nxt)
            ST_A_SET, ST_A_WR, ST_A_HLD: begin
                w_cs_n   = 1'b0;
                w_ad_sel = 1'b0;
                w_ad_oe  = 1'b1;
                w_ad_out = addr_of(w_idx_nxt);
                w_wr_n   = (w_state_nxt != ST_A_WR);
            end
            ST_D_SET: w_cs_n = 1'b0;
            ST_D_RD: begin
                w_cs_n = 1'b0;
                w_rd_n = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cs_n    <= 1'b1;
            r_rd_n    <= 1'b1;
            r_wr_n    <= 1'b1;
            r_ad_oe   <= 1'b0;
            r_ad_sel  <= 1'b1;
            r_ad_out  <= 8'h00;
            r_ocupado <= 1'b0;
            r_listo   <= 1'b0;
        end else begin
            r_cs_n    <= w_cs_n;
            r_rd_n    <= w_rd_n;
            r_wr_n    <= w_wr_n;
            r_ad_oe   <= w_ad_oe;
            r_ad_sel  <= w_ad_sel;
            r_ad_out  <= w_ad_out;
            r_ocupado <= (w_state_nxt != ST_IDLE);
            r_listo   <= (w_state_nxt == ST_COMMIT);
        end
    end

    // Shadow fills one byte per register; datos only move on the single commit cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 11; i++) begin
                r_shadow[i] <= 8'h00;
                r_datos[i]  <= 8'h00;
            end
        end else begin
            for (int i = 0; i < 11; i++) begin
                if ((r_state == ST_D_RD) && w_tc && (r_idx == 4'(i))) begin
                    r_shadow[i] <= AD_in;
                end
                if (w_state_nxt == ST_COMMIT) begin
                    r_datos[i] <= r_shadow[i];
                end
            end
        end
    end

    assign AD_out  = r_ad_out;
    assign ad_oe   = r_ad_oe;
    assign ad_sel  = r_ad_sel;
    assign cs_n    = r_cs_n;
    assign rd_n    = r_rd_n;
    assign wr_n    = r_wr_n;
    assign ocupado = r_ocupado;
    assign listo   = r_listo;
    assign datos0  = r_datos[0];
    assign datos1  = r_datos[1];
    assign datos2  = r_datos[2];
    assign datos3  = r_datos[3];
    assign datos4  = r_datos[4];
    assign datos5  = r_datos[5];
    assign datos6  = r_datos[6];
    assign datos7  = r_datos[7];
    assign datos8  = r_datos[8];
    assign datos9  = r_datos[9];
    assign datos10 = r_datos[10];

endmodule

`default_nettype wire

// File: doc/lectura_rtc.md
# lectura_rtc

Read controller for the real-time-clock chip's multiplexed address/data bus. On each start request it runs an address-write/data-read cycle for eleven registers, then presents them atomically as `datos0`..`datos10`. Clock/calendar registers come first, then timer registers. It is the producer that feeds the display interface's packed-BCD data inputs. Captured bytes are held in a shadow buffer and committed in one cycle, so the display never samples a partially updated set.

## Interface
- `TPULSE`, 4: cycles per bus phase (≥1); counter sized to hold `TPULSE-1`.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `iniciar`  in  1  start a full read sweep; sampled only in IDLE.
- `AD_in`  in  8  data driven by the RTC during read phase.
- `AD_out`  out  8  address driven to the RTC.
- `ad_oe`  out  1  tristate enable for `AD_out` (1 = FPGA drives bus).
- `ad_sel`  out  1  A/D line: 0 = address cycle, 1 = data cycle.
- `cs_n`, `rd_n`, `wr_n`  out  1 each  active-low chip select, read strobe, write strobe.
- `ocupado`  out  1  high whenever state ≠ IDLE.
- `listo`  out  1  one-cycle pulse, coincident with new `datos*`.
- `datos0`..`datos10`  out  8 each  packed BCD (`[7:4]` tens, `[3:0]` units).
  - `datos0`..`datos7`: seconds, minutes, hours, date, month, year, weekday, week number.
  - `datos8`..`datos10`: timer seconds, minutes, hours.

## Operation
- Fixed address table, index 0..10: 0x21, 0x22, 0x23, 0x24, 0x25, 0x26, 0x27, 0x28, 0x41, 0x42, 0x43.
- States: IDLE, A_SET, A_WR, A_HLD, D_SET, D_RD, D_HLD, COMMIT.
- Phase counter and register index:
  - Each phase state except IDLE/COMMIT lasts exactly `TPULSE` cycles; the phase counter restarts at 0 on every state entry.
  - 4-bit register index `idx` is cleared on IDLE→A_SET.
- Outputs per state:
  - IDLE: `cs_n=rd_n=wr_n=1`, `ad_oe=0`, `ad_sel=1`.
  - A_SET: `cs_n=0`, `ad_sel=0`, `ad_oe=1`, `AD_out=table[idx]`.
  - A_WR: as A_SET, plus `wr_n=0`.
  - A_HLD: as A_SET, with `wr_n=1`.
  - D_SET: `cs_n=0`, `ad_sel=1`, `ad_oe=0`.
  - D_RD: as D_SET, plus `rd_n=0`; on the last cycle of D_RD, `shadow[idx] <= AD_in`.
  - D_HLD: `rd_n=1`, `cs_n=1`, `ad_oe=0`.
- Transitions:
  - IDLE → A_SET when `iniciar`=1.
  - A_SET → A_WR → A_HLD → D_SET → D_RD → D_HLD, each on phase-counter terminal count.
  - D_HLD terminal with `idx<10`: `idx+1`, go to A_SET.
  - D_HLD terminal with `idx=10`: go to COMMIT.
  - COMMIT (1 cycle): all `datos*` ← shadow, `listo`=1, then IDLE.
- All outputs are registered; no combinational path from `AD_in` to any output.
- `ad_oe` and `rd_n` are never simultaneously 1/0 (no bus contention). `wr_n` and `rd_n` are never both 0.
- `iniciar` while `ocupado`: ignored, not queued.
- Reset (any time, including mid-sweep):
  - All `datos*` = 0x00, shadow = 0x00.
  - `cs_n=rd_n=wr_n=1`, `ad_oe=0`, `ad_sel=1`, `AD_out=0`.
  - `ocupado=0`, `listo=0`, state IDLE, `idx=0`.
  - After reset, `datos*` hold their old value (0x00) until the next complete COMMIT; a partial sweep never reaches outputs.
- Only bits `[7:0]` of `AD_in` are used; no BCD validation (the display path masks to nibbles).

## Timing
- `iniciar` high at edge k → A_SET from cycle k+1; `ocupado` high from k+1.
- Per register: 6·`TPULSE` cycles. Full sweep: 66·`TPULSE` cycles, then COMMIT.
- `listo` and new `datos*` are visible in cycle k+1+66·`TPULSE`. With `TPULSE`=4: cycle k+265.
- IDLE reached the cycle after COMMIT. `iniciar` held high re-triggers one cycle after `listo`, giving back-to-back sweeps with a 1-cycle IDLE gap.
- `TPULSE`=1: each phase is one cycle; sweep = 66 cycles.

## Test plan
- Reset low mid-sweep (during D_RD of idx 5) → next edge-independent: `cs_n=rd_n=wr_n=1`, `ad_oe=0`, `ocupado=0`, all `datos*`=0x00; no `listo` until a fresh full sweep.
- RTC model returns `addr ^ 0x5A` (0x21→0x7B … 0x43→0x19), `TPULSE`=4, single `iniciar` pulse → `listo` exactly 265 cycles later, `datos0`=0x7B, `datos10`=0x19, address sequence matches the table.
- Bus checker over full sweep → `wr_n` low exactly 11 windows of 4 cycles with `ad_sel=0`; `rd_n` low 11 windows with `ad_oe=0`; never `ad_oe=1` while `rd_n=0`.
- Second `iniciar` pulse at cycle 100 of a sweep → ignored; exactly one `listo`; `datos*` change only on the `listo` cycle.
- Model changes seconds value from 0x59 to 0x00 mid-sweep (after idx 0 sampled) → committed `datos0`=0x59, unchanged until the next sweep.
- `TPULSE`=1, `iniciar` held high → `listo` pulses every 68 cycles.
